// File: rtl/autoc_window.sv
// autoc_window: windowed complex lag autocorrelator with fill gating, scaled output and threshold/hold preamble detector.
// Define AUTOC_WINDOW_ROUND_EN for round-half-up output scaling with positive saturation (default: truncation).
module autoc_window #(
  parameter int WIDTH    = 16,
  parameter int LAG      = 32,
  parameter int WIN_LOG2 = 4,
  parameter int OWIDTH   = 24,
  parameter int HOLD     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [2*WIDTH-1:0]       ddc_out_sample,
  input  logic                     ddc_out_strobe,
  input  logic [OWIDTH-1:0]        thresh,
  output logic signed [OWIDTH-1:0] si,
  output logic signed [OWIDTH-1:0] sq,
  output logic                     out_strobe,
  output logic                     outputting,
  output logic                     detect
);
  localparam int W     = 1 << WIN_LOG2;
  localparam int PW    = 2*WIDTH + 1;
  localparam int ACC_W = PW + WIN_LOG2;
  localparam int SH    = ACC_W - OWIDTH;
  localparam int FILL  = LAG + W;
  localparam int NW    = $clog2(FILL + 1);
  localparam int LW    = LAG > 1 ? $clog2(LAG) : 1;
  localparam int WP    = WIN_LOG2 > 0 ? WIN_LOG2 : 1;
  typedef enum logic [1:0] {SEARCH, COUNT, LOCKED} state_t;
  logic [2*WIDTH-1:0] dl [LAG];
  logic [2*PW-1:0] pl [W];
  logic [LW-1:0] rp;
  logic [WP-1:0] wp;
  logic [NW-1:0] n;
  logic take, v1, v2, full1, last1, last2, eval, ge, fire;
  logic signed [WIDTH-1:0] xi, xq, di, dq;
  logic signed [2*WIDTH-1:0] m_ii, m_qq, m_qi, m_iq;
  logic signed [PW-1:0] pr, pi, pr_r, pi_r, old_r, old_i;
  logic signed [ACC_W-1:0] acc_r, acc_i;
  logic signed [OWIDTH-1:0] si_n, sq_n;
  logic [OWIDTH-1:0] ai, aq;
  logic [OWIDTH:0] m;
  logic [7:0] cnt, cnt_n;
  state_t state, state_n;
  function automatic logic signed [OWIDTH-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef AUTOC_WINDOW_ROUND_EN
    logic signed [ACC_W:0] r;
    r = (ACC_W+1)'(a) + (((ACC_W+1)'(1) << SH) >> 1);
    r = r >>> SH;
    scale = (r[OWIDTH-1] & ~r[ACC_W]) ? {1'b0, {(OWIDTH-1){1'b1}}} : r[OWIDTH-1:0];
`else
    scale = OWIDTH'(a >>> SH);
`endif
  endfunction
  assign take = ddc_out_strobe & ~clear;
  assign xi = ddc_out_sample[2*WIDTH-1:WIDTH];
  assign xq = ddc_out_sample[WIDTH-1:0];
  // delayed sample reads as zero until LAG samples have been written since the last flush
  assign {di, dq} = (n >= NW'(LAG)) ? dl[rp] : '0;
  assign m_ii = xi * di;
  assign m_qq = xq * dq;
  assign m_qi = xq * di;
  assign m_iq = xi * dq;
  assign pr = {m_ii[2*WIDTH-1], m_ii} + {m_qq[2*WIDTH-1], m_qq};
  assign pi = {m_qi[2*WIDTH-1], m_qi} - {m_iq[2*WIDTH-1], m_iq};
  assign {old_r, old_i} = full1 ? pl[wp] : '0;
  assign si_n = scale(acc_r);
  assign sq_n = scale(acc_i);
  assign ai = si_n[OWIDTH-1] ? OWIDTH'(-si_n) : si_n;
  assign aq = sq_n[OWIDTH-1] ? OWIDTH'(-sq_n) : sq_n;
  assign m = {1'b0, ai} + {1'b0, aq};
  assign ge = m >= {1'b0, thresh};
  assign eval = v2 & (outputting | last2);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    fire = 1'b0;
    if (eval)
      case (state)
        SEARCH, COUNT:
          if (ge) begin
            cnt_n = state == SEARCH ? 8'd1 : cnt + 8'd1;
            fire = cnt_n == 8'(HOLD);
            state_n = fire ? LOCKED : COUNT;
          end else state_n = SEARCH;
        default: state_n = ge ? LOCKED : SEARCH;
      endcase
  end
  always_ff @(posedge clk) if (take) dl[rp] <= ddc_out_sample;
  always_ff @(posedge clk) if (v1) pl[wp] <= {pr_r, pi_r};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rp, wp, n, v1, v2, full1, last1, last2, pr_r, pi_r, acc_r, acc_i, cnt} <= '0;
      {si, sq, out_strobe, outputting, detect} <= '0;
      state <= SEARCH;
    end else if (clear) begin
      {rp, wp, n, v1, v2, full1, last1, last2, pr_r, pi_r, acc_r, acc_i, cnt} <= '0;
      {si, sq, out_strobe, outputting, detect} <= '0;
      state <= SEARCH;
    end else begin
      v1 <= take;
      if (take) begin
        rp <= rp == LW'(LAG - 1) ? '0 : rp + 1'b1;
        n <= n == NW'(FILL) ? n : n + 1'b1;
        pr_r <= pr;
        pi_r <= pi;
        full1 <= n == NW'(FILL);
        last1 <= n == NW'(FILL - 1);
      end
      v2 <= v1;
      if (v1) begin
        acc_r <= acc_r + ACC_W'(pr_r) - ACC_W'(old_r);
        acc_i <= acc_i + ACC_W'(pi_r) - ACC_W'(old_i);
        wp <= WIN_LOG2 == 0 ? '0 : wp + 1'b1;
        last2 <= last1;
      end
      out_strobe <= v2;
      detect <= fire;
      if (v2) begin
        si <= si_n;
        sq <= sq_n;
        outputting <= outputting | last2;
      end
      state <= state_n;
      cnt <= cnt_n;
    end
endmodule

// File: tb/tb_autoc_window.sv
// tb_autoc_window: directed checks of autoc_window (LAG=4, W=4, OWIDTH=24, HOLD=4) against hand-derived values.
module tb_autoc_window;
  localparam int SH = 11;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, ddc_out_strobe = 1'b0;
  logic [31:0] ddc_out_sample = '0;
  logic [23:0] thresh = 24'd2048;
  logic signed [23:0] si, sq;
  logic out_strobe, outputting, detect;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int si; int sq; bit o; bit d; int cyc;} rec_t;
  rec_t oq[$];
  int st_q[$];
  autoc_window #(.WIDTH(16), .LAG(4), .WIN_LOG2(2), .OWIDTH(24), .HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ddc_out_sample(ddc_out_sample),
    .ddc_out_strobe(ddc_out_strobe), .thresh(thresh), .si(si), .sq(sq),
    .out_strobe(out_strobe), .outputting(outputting), .detect(detect));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ddc_out_strobe && !clear) st_q.push_back(cyc);
    if (out_strobe) oq.push_back('{int'(si), int'(sq), outputting, detect, cyc});
  end
  function automatic int scl(longint v);
`ifdef AUTOC_WINDOW_ROUND_EN
    return int'((v + 1024) >>> SH);
`else
    return int'(v >>> SH);
`endif
  endfunction
  function automatic int ramp(int k);
    return k < 4 ? 0 : (k > 7 ? 2048 : (k - 3) * 512);
  endfunction
  function automatic int rnd(real v);
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic expect_out(input string tag, input int k, input int esi, input int esq, input int eo, input int ed);
    bit ok;
    ok = oq.size() > k && st_q.size() > k;
    chk($sformatf("%s[%0d] present", tag, k), int'(ok), 1);
    if (ok) begin
      chk($sformatf("%s[%0d] si", tag, k), oq[k].si, esi);
      chk($sformatf("%s[%0d] sq", tag, k), oq[k].sq, esq);
      chk($sformatf("%s[%0d] outputting", tag, k), int'(oq[k].o), eo);
      chk($sformatf("%s[%0d] detect", tag, k), int'(oq[k].d), ed);
      chk($sformatf("%s[%0d] latency", tag, k), oq[k].cyc - st_q[k], 3);
    end
  endtask
  task automatic step(input int i, input int q, input bit s, input bit c);
    ddc_out_sample = {i[15:0], q[15:0]};
    ddc_out_strobe = s;
    clear = c;
    @(posedge clk);
    #1;
    ddc_out_strobe = 1'b0;
    clear = 1'b0;
  endtask
  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic flush();
    step(0, 0, 1'b0, 1'b1);
    idle(1);
    oq.delete();
    st_q.delete();
  endtask
  initial begin
    int xi[24], xq[24];
    longint re, im;
    idle(3);
    chk("rst si", int'(si), 0);
    chk("rst sq", int'(sq), 0);
    chk("rst out_strobe", int'(out_strobe), 0);
    chk("rst outputting", int'(outputting), 0);
    chk("rst detect", int'(detect), 0);
    rst_n = 1'b1;
    idle(2);
    // ramp, fill and single detect, back-to-back strobes
    for (int k = 0; k < 12; k++) step(1024, 0, 1'b1, 1'b0);
    idle(6);
    chk("s1 count", oq.size(), 12);
    for (int k = 0; k < 12; k++) expect_out("s1", k, ramp(k), 0, int'(k >= 7), int'(k == 10));
    // drop to zero (re-arm), restore (second detect)
    oq.delete();
    st_q.delete();
    for (int k = 0; k < 8; k++) step(0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1024, 0, 1'b1, 1'b0);
    idle(6);
    chk("s5 count", oq.size(), 20);
    for (int k = 0; k < 20; k++)
      expect_out("s5", k, k < 8 ? (k < 3 ? (3 - k) * 512 : 0) : ramp(k - 8), 0, 1, int'(k == 18));
    // small constant: scaling truncation vs rounding
    flush();
    for (int k = 0; k < 10; k++) step(16, 0, 1'b1, 1'b0);
    idle(6);
    chk("s2 count", oq.size(), 10);
    for (int k = 0; k < 10; k++)
      expect_out("s2", k, scl(k < 4 ? 0 : (k > 7 ? 4 : k - 3) * 256), 0, int'(k >= 7), 0);
    // rotating phasor, exact reference sum
    flush();
    for (int k = 0; k < 24; k++) begin
      xi[k] = rnd(8000.0 * $cos(3.14159265358979 * k / 8.0));
      xq[k] = rnd(8000.0 * $sin(3.14159265358979 * k / 8.0));
      step(xi[k], xq[k], 1'b1, 1'b0);
    end
    idle(6);
    chk("s3 count", oq.size(), 24);
    for (int k = 0; k < 24; k++) begin
      re = 0;
      im = 0;
      for (int j = 0; j < 4; j++)
        if (k - j >= 4) begin
          re += longint'(xi[k-j]) * xi[k-j-4] + longint'(xq[k-j]) * xq[k-j-4];
          im += longint'(xq[k-j]) * xi[k-j-4] - longint'(xi[k-j]) * xq[k-j-4];
        end
      expect_out("s3", k, scl(re), scl(im), int'(k >= 7), int'(k == 10));
    end
    // strobe every third cycle
    flush();
    for (int k = 0; k < 12; k++) begin
      step(1024, 0, 1'b1, 1'b0);
      idle(2);
    end
    idle(6);
    chk("s4 count", oq.size(), 12);
    for (int k = 0; k < 12; k++) expect_out("s4", k, ramp(k), 0, int'(k >= 7), int'(k == 10));
    // async reset mid-run
    flush();
    for (int k = 0; k < 10; k++) step(1024, 0, 1'b1, 1'b0);
    chk("s6 pre si", int'(si), 2048);
    chk("s6 pre outputting", int'(outputting), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6 rst si", int'(si), 0);
    chk("s6 rst sq", int'(sq), 0);
    chk("s6 rst out_strobe", int'(out_strobe), 0);
    chk("s6 rst outputting", int'(outputting), 0);
    chk("s6 rst detect", int'(detect), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // clear with strobe squashes the sample and in-flight stages
    step(1024, 0, 1'b1, 1'b0);
    step(1024, 0, 1'b1, 1'b0);
    step(3000, 500, 1'b1, 1'b1);
    oq.delete();
    st_q.delete();
    chk("s6 clr out_strobe", int'(out_strobe), 0);
    chk("s6 clr si", int'(si), 0);
    idle(6);
    chk("s6 squash", oq.size(), 0);
    for (int k = 0; k < 12; k++) step(1024, 0, 1'b1, 1'b0);
    idle(6);
    chk("s6 count", oq.size(), 12);
    for (int k = 0; k < 12; k++) expect_out("s6", k, ramp(k), 0, int'(k >= 7), int'(k == 10));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/autoc_window.md
Name: autoc_window

Overview:
- Parametrised delay-and-correlate engine; successor to the fixed-width autocorrelator on the DDC output path.
- Computes the windowed complex lag autocorrelation R[n] = sum over k=0..W-1 of x[n-k]*conj(x[n-k-LAG]) on strobed I/Q samples.
- Adds a fill-aware startup, a scaled output, and a threshold/hold preamble detector feeding the packet/timing logic downstream.

Parameters:
WIDTH, 16, bits per I and Q component (signed two's complement)
LAG, 32, correlation lag in accepted samples (1..1024)
WIN_LOG2, 4, window length W = 2^WIN_LOG2 samples (0..8)
OWIDTH, 24, output component width; must be <= 2*WIDTH+1+WIN_LOG2
HOLD, 4, consecutive above-threshold outputs required to fire detect (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush; returns block to post-reset state
ddc_out_sample  in  2*WIDTH  {I[2*WIDTH-1:WIDTH], Q[WIDTH-1:0]}
ddc_out_strobe  in  1  sample valid, one cycle per sample, arbitrary gaps
thresh  in  OWIDTH  unsigned detection threshold on metric
si  out  OWIDTH  real part of scaled R
sq  out  OWIDTH  imaginary part of scaled R
out_strobe  out  1  si/sq valid
outputting  out  1  high once the window holds only valid products
detect  out  1  one-cycle pulse, coincident with out_strobe

Behaviour:
- Reset (rst_n low, async) or clear (sync): si, sq, out_strobe, outputting, detect = 0; accumulator 0; fill count n = 0; FSM = SEARCH. Delay RAMs are not cleared.
- Sample delay line (depth LAG) and product line (depth W) advance only on ddc_out_strobe; no strobe = no state change.
- Fill gating: n counts accepted strobes, saturating at LAG+W. d = x[n-LAG], forced to 0 while n < LAG. Product leaving the window is forced to 0 while n < LAG+W. Result: the accumulator is exact from the first sample, with no stale RAM contents.
- Arithmetic:
  - pr = I*Id + Q*Qd and pi = Q*Id - I*Qd, each 2*WIDTH+1 bits signed.
  - acc += p_new - p_old, ACC_W = 2*WIDTH+1+WIN_LOG2 bits; cannot overflow.
  - si/sq = acc >> (ACC_W-OWIDTH), arithmetic shift, truncation (see optional feature).
- Pipeline: strobe at cycle t -> product registered t+1 -> accumulator t+2 -> si/sq/out_strobe at t+3. Fixed latency 3, independent of gaps. Back-to-back strobes every cycle are supported.
- outputting: set on the out_strobe for the sample that makes n reach LAG+W; held until reset/clear.
- Metric m = |si|+|sq|, unsigned OWIDTH+1 bits; only evaluated on out_strobe while outputting = 1.
- Detector FSM:
  - SEARCH: m >= thresh -> cnt=1, go to COUNT; if HOLD=1, fire detect and go to LOCKED instead.
  - COUNT: m >= thresh -> cnt++; when cnt reaches HOLD, fire detect and go to LOCKED. m < thresh -> SEARCH.
  - LOCKED: stay while m >= thresh; m < thresh -> SEARCH (re-arm). No further detect while LOCKED.
  - thresh is sampled on each evaluation; a change mid-COUNT applies immediately.
- clear concurrent with strobe: clear wins and the sample is discarded. In-flight pipeline stages are squashed, so no out_strobe appears after clear.

Optional Feature:
AUTOC_WINDOW_ROUND_EN
- Defined: si/sq use round-half-up, adding 2^(ACC_W-OWIDTH-1) before the shift, with saturation at the positive full-scale value.
- Undefined: plain truncation, which uses less logic.
- Latency and all other behaviour are unchanged in both cases.

Test Plan:
1. WIDTH=16, LAG=4, WIN_LOG2=2, OWIDTH=24, constant (1024,0) every cycle -> out_strobe 3 cycles after each strobe. si ramps 0,0,0,0,512,1024,1536,2048, then holds 2048; sq=0; outputting rises with the 8th output.
2. Same config, constant (16,0) -> steady si=0 with truncation; si=1 with AUTOC_WINDOW_ROUND_EN (acc=1024, shift 11).
3. Same config, x[n]=round(8000*e^(j*pi*n/8)) -> steady sq = 4*64e6>>11 = 125000 (+/-1); |si| <= 1.
4. Strobe every third cycle vs every cycle, same sequence as scenario 1 -> identical si/sq value sequence; latency 3 in both cases.
5. HOLD=4, thresh=2048, steady scenario 1 -> single detect pulse on the 4th output after outputting rises. Drop input to 0 -> back to SEARCH; restore input -> second detect.
6. rst_n low mid-run, then clear asserted together with a strobe -> all outputs 0 immediately; no out_strobe for the dropped sample; refill is identical to scenario 1.
